// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - VGA timing bundle shared by the generator and all draw stages
//
// Signals:
//   hcount, vcount  [10:0]  pixel / line position the other signals describe
//   hsync, vsync            active-high sync pulses
//   hblnk, vblnk            blanking (outside the visible area)
// Modports:
//   out  - driven by vga_timing_ctrl
//   in   - consumed by background/rect/char stages
interface vga_tim;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - programmable VGA timing generator with frame-boundary mode switching
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-high reset
//   en                  count enable; low freezes counters, outputs and the apply point
//   cfg_valid/cfg_ready configuration handshake
//   cfg_h_*, cfg_v_*    offered timing fields (active, front porch, sync, back porch)
//   frame_start         one-cycle pulse with hcount=0, vcount=0
//   cfg_applied         one-cycle pulse on the frame-wrap cycle that activates a pending config
//   cfg_err             (VGA_TIM_CFG_CHECK_EN only) one-cycle pulse on a rejected offer
//   tim_out             vga_tim.out timing bundle
//
// Optional feature macro: VGA_TIM_CFG_CHECK_EN
//   When defined, offers with a zero field or a total above 2047 are consumed but rejected.
//   When undefined, every offer is captured and totals wrap to 11 bits.
module vga_timing_ctrl #(
  parameter int H_ACTIVE_D = 800,
  parameter int H_FP_D     = 40,
  parameter int H_SYNC_D   = 128,
  parameter int H_BP_D     = 88,
  parameter int V_ACTIVE_D = 600,
  parameter int V_FP_D     = 1,
  parameter int V_SYNC_D   = 4,
  parameter int V_BP_D     = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_h_active,
  input  logic [10:0] cfg_h_fp,
  input  logic [10:0] cfg_h_sync,
  input  logic [10:0] cfg_h_bp,
  input  logic [10:0] cfg_v_active,
  input  logic [10:0] cfg_v_fp,
  input  logic [10:0] cfg_v_sync,
  input  logic [10:0] cfg_v_bp,
  output logic        frame_start,
  output logic        cfg_applied,
`ifdef VGA_TIM_CFG_CHECK_EN
  output logic        cfg_err,
`endif
  vga_tim.out         tim_out
);

  typedef enum logic {IDLE, PENDING} state_t;
  state_t state;

  // Active timing fields
  logic [10:0] h_active, h_fp, h_sync, h_bp;
  logic [10:0] v_active, v_fp, v_sync, v_bp;
  // Shadow copy of an accepted offer, waiting for the frame wrap
  logic [10:0] s_h_active, s_h_fp, s_h_sync, s_h_bp;
  logic [10:0] s_v_active, s_v_fp, s_v_sync, s_v_bp;

  logic [10:0] hc, vc;
  logic [10:0] h_tot, v_tot, h_last, v_last;
  logic [11:0] hs_start, hs_end, vs_start, vs_end;
  logic        at_line_end, at_frame_end;
  logic        offer_ok;

  // Totals wrap to counter width; sync window edges keep a 12th bit so the
  // comparisons stay exact for large porches.
  assign h_tot    = h_active + h_fp + h_sync + h_bp;
  assign v_tot    = v_active + v_fp + v_sync + v_bp;
  assign h_last   = h_tot - 11'd1;
  assign v_last   = v_tot - 11'd1;
  assign hs_start = {1'b0, h_active} + {1'b0, h_fp};
  assign hs_end   = hs_start + {1'b0, h_sync};
  assign vs_start = {1'b0, v_active} + {1'b0, v_fp};
  assign vs_end   = vs_start + {1'b0, v_sync};

  assign at_line_end  = (hc == h_last);
  assign at_frame_end = at_line_end && (vc == v_last);

`ifdef VGA_TIM_CFG_CHECK_EN
  // 13-bit sums so four 11-bit fields cannot wrap back under the limit
  logic [12:0] chk_h_tot, chk_v_tot;
  assign chk_h_tot = 13'(cfg_h_active) + 13'(cfg_h_fp) + 13'(cfg_h_sync) + 13'(cfg_h_bp);
  assign chk_v_tot = 13'(cfg_v_active) + 13'(cfg_v_fp) + 13'(cfg_v_sync) + 13'(cfg_v_bp);
  assign offer_ok  = (cfg_h_active != '0) && (cfg_h_fp != '0) && (cfg_h_sync != '0) &&
                     (cfg_h_bp != '0) && (cfg_v_active != '0) && (cfg_v_fp != '0) &&
                     (cfg_v_sync != '0) && (cfg_v_bp != '0) &&
                     (chk_h_tot <= 13'd2047) && (chk_v_tot <= 13'd2047);
`else
  assign offer_ok = 1'b1;
`endif

  // Config FSM: capture into shadow, swap into active on the frame-wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      cfg_applied <= 1'b0;
      h_active    <= 11'(H_ACTIVE_D);
      h_fp        <= 11'(H_FP_D);
      h_sync      <= 11'(H_SYNC_D);
      h_bp        <= 11'(H_BP_D);
      v_active    <= 11'(V_ACTIVE_D);
      v_fp        <= 11'(V_FP_D);
      v_sync      <= 11'(V_SYNC_D);
      v_bp        <= 11'(V_BP_D);
      s_h_active  <= '0;
      s_h_fp      <= '0;
      s_h_sync    <= '0;
      s_h_bp      <= '0;
      s_v_active  <= '0;
      s_v_fp      <= '0;
      s_v_sync    <= '0;
      s_v_bp      <= '0;
`ifdef VGA_TIM_CFG_CHECK_EN
      cfg_err     <= 1'b0;
`endif
    end else begin
      cfg_applied <= 1'b0;
`ifdef VGA_TIM_CFG_CHECK_EN
      cfg_err     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cfg_valid && offer_ok) begin
            s_h_active <= cfg_h_active;
            s_h_fp     <= cfg_h_fp;
            s_h_sync   <= cfg_h_sync;
            s_h_bp     <= cfg_h_bp;
            s_v_active <= cfg_v_active;
            s_v_fp     <= cfg_v_fp;
            s_v_sync   <= cfg_v_sync;
            s_v_bp     <= cfg_v_bp;
            cfg_ready  <= 1'b0;
            state      <= PENDING;
          end
`ifdef VGA_TIM_CFG_CHECK_EN
          if (cfg_valid && !offer_ok) cfg_err <= 1'b1;
`endif
        end
        PENDING: begin
          // Swapping only when both counters are about to return to 0 means a
          // shorter new total can never strand the counters past their end.
          if (en && at_frame_end) begin
            h_active    <= s_h_active;
            h_fp        <= s_h_fp;
            h_sync      <= s_h_sync;
            h_bp        <= s_h_bp;
            v_active    <= s_v_active;
            v_fp        <= s_v_fp;
            v_sync      <= s_v_sync;
            v_bp        <= s_v_bp;
            cfg_applied <= 1'b1;
            cfg_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counters and registered decode. Outputs describe the counter value of the
  // previous cycle, so hcount/vcount and all flags stay mutually aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc             <= '0;
      vc             <= '0;
      tim_out.hcount <= '0;
      tim_out.vcount <= '0;
      tim_out.hsync  <= 1'b0;
      tim_out.vsync  <= 1'b0;
      tim_out.hblnk  <= 1'b0;
      tim_out.vblnk  <= 1'b0;
      frame_start    <= 1'b0;
    end else if (en) begin
      tim_out.hcount <= hc;
      tim_out.vcount <= vc;
      tim_out.hblnk  <= (hc >= h_active);
      tim_out.vblnk  <= (vc >= v_active);
      tim_out.hsync  <= ({1'b0, hc} >= hs_start) && ({1'b0, hc} < hs_end);
      tim_out.vsync  <= ({1'b0, vc} >= vs_start) && ({1'b0, vc} < vs_end);
      frame_start    <= (hc == '0) && (vc == '0);
      if (at_line_end) begin
        hc <= '0;
        vc <= at_frame_end ? 11'd0 : vc + 11'd1;
      end else begin
        hc <= hc + 11'd1;
      end
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl against a linear-position model
module tb_vga_timing_ctrl;
  // Small defaults keep whole frames inside the simulation budget.
  localparam int HA = 20, HF = 3, HS = 4, HB = 5;
  localparam int VA = 12, VF = 2, VS = 3, VB = 4;
  localparam int DEF_FRAME = (HA + HF + HS + HB) * (VA + VF + VS + VB);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready, frame_start, cfg_applied;
  logic [10:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [10:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
`ifdef VGA_TIM_CFG_CHECK_EN
  logic cfg_err;
  logic exp_err;
  int   n_err = 0;
`endif

  int offer [8];
  assign cfg_h_active = 11'(offer[0]);
  assign cfg_h_fp     = 11'(offer[1]);
  assign cfg_h_sync   = 11'(offer[2]);
  assign cfg_h_bp     = 11'(offer[3]);
  assign cfg_v_active = 11'(offer[4]);
  assign cfg_v_fp     = 11'(offer[5]);
  assign cfg_v_sync   = 11'(offer[6]);
  assign cfg_v_bp     = 11'(offer[7]);

  vga_tim tim ();

  vga_timing_ctrl #(
    .H_ACTIVE_D(HA), .H_FP_D(HF), .H_SYNC_D(HS), .H_BP_D(HB),
    .V_ACTIVE_D(VA), .V_FP_D(VF), .V_SYNC_D(VS), .V_BP_D(VB)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .frame_start(frame_start), .cfg_applied(cfg_applied),
`ifdef VGA_TIM_CFG_CHECK_EN
    .cfg_err(cfg_err),
`endif
    .tim_out(tim)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the raster is a single pixel index pos within the frame.
  int          act [8];
  int          shd [8];
  bit          pending;
  int          pos;
  logic [28:0] exp_v;
  int          cyc = 0, last_fs = -1, fs_period = 0, n_applied = 0;
  bit          rand_en = 1'b0;
  logic [10:0] h_hold;

  function automatic int h_total();
    return act[0] + act[1] + act[2] + act[3];
  endfunction

  function automatic int frame_len();
    return h_total() * (act[4] + act[5] + act[6] + act[7]);
  endfunction

  function automatic logic [25:0] timing_at(int p);
    int ht, hc, vc;
    ht = h_total();
    hc = p % ht;
    vc = p / ht;
    return {hc[10:0], vc[10:0],
            (hc >= act[0] + act[1]) && (hc < act[0] + act[1] + act[2]),
            (vc >= act[4] + act[5]) && (vc < act[4] + act[5] + act[6]),
            hc >= act[0], vc >= act[4]};
  endfunction

  function automatic bit offer_ok();
`ifdef VGA_TIM_CFG_CHECK_EN
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (offer[i] == 0) ok = 1'b0;
    if (offer[0] + offer[1] + offer[2] + offer[3] > 2047) ok = 1'b0;
    if (offer[4] + offer[5] + offer[6] + offer[7] > 2047) ok = 1'b0;
    return ok;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [28:0] obs_vec();
    return {tim.hcount, tim.vcount, tim.hsync, tim.vsync, tim.hblnk, tim.vblnk,
            frame_start, cfg_applied, cfg_ready};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic cycle();
    int ft;
    bit app;
    if (rand_en) en = ($urandom_range(0, 3) != 0);
    ft  = frame_len();
    app = 1'b0;
`ifdef VGA_TIM_CFG_CHECK_EN
    exp_err = 1'b0;
`endif
    if (en) begin
      app   = pending && (pos == ft - 1);
      exp_v = {timing_at(pos), pos == 0, app, 1'b0};
      pos   = (pos + 1) % ft;
    end else begin
      exp_v[2:1] = 2'b00;
    end
    if (pending) begin
      if (app) begin
        act     = shd;
        pending = 1'b0;
      end
    end else if (cfg_valid) begin
      if (offer_ok()) begin
        shd     = offer;
        pending = 1'b1;
      end
`ifdef VGA_TIM_CFG_CHECK_EN
      else exp_err = 1'b1;
`endif
    end
    exp_v[0] = !pending;
    @(posedge clk);
    #1;
    cyc++;
    check("cycle", 32'(obs_vec()), 32'(exp_v));
`ifdef VGA_TIM_CFG_CHECK_EN
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (cfg_err) n_err++;
`endif
    if (cfg_applied) n_applied++;
    if (frame_start) begin
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    act     = '{HA, HF, HS, HB, VA, VF, VS, VB};
    pending = 1'b0;
    pos     = 0;
    exp_v   = 29'd1;
    last_fs = -1;
    check("reset", 32'(obs_vec()), 32'(exp_v));
`ifdef VGA_TIM_CFG_CHECK_EN
    check("reset_err", 32'(cfg_err), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    offer = '{HA, HF, HS, HB, VA, VF, VS, VB};
    #2;
    do_reset();

    // Default timing, two full frames
    en = 1'b1;
    run(2 * DEF_FRAME + 4);
    check("fs_period_default", 32'(fs_period), 32'(DEF_FRAME));

    // Freeze mid-line
    for (int k = 0; k < 64 && (pos % h_total()) != 10; k++) cycle();
    h_hold = exp_v[28:18];
    en = 1'b0;
    run(10);
    check("en_hold_hcount", 32'(tim.hcount), 32'(h_hold));
    check("en_hold_fs", 32'(frame_start), 32'd0);
    en = 1'b1;
    run(5);

    // Mid-frame offer, then a second offer while pending
    n_applied = 0;
    offer = '{10, 2, 3, 4, 8, 1, 2, 3};
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    check("ready_drop", 32'(cfg_ready), 32'd0);
    offer = '{5, 1, 1, 1, 5, 1, 1, 1};
    cfg_valid = 1'b1;
    run(3);
    cfg_valid = 1'b0;
    check("ready_pending", 32'(cfg_ready), 32'd0);
    for (int k = 0; k < DEF_FRAME + 8 && n_applied == 0; k++) cycle();
    check("applied_once", 32'(n_applied), 32'd1);
    run(3);
    check("ready_back", 32'(cfg_ready), 32'd1);
    check("applied_total", 32'(n_applied), 32'd1);
    last_fs = -1;
    run(2 * 266 + 4);
    check("fs_period_new", 32'(fs_period), 32'd266);

    // Offer on the exact frame-wrap cycle: applied one frame later
    for (int k = 0; k < 600 && pos != frame_len() - 1; k++) cycle();
    offer = '{6, 1, 2, 2, 6, 1, 1, 2};
    n_applied = 0;
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    run(3);
    check("wrap_no_apply", 32'(n_applied), 32'd0);
    run(266 + 4);
    check("wrap_apply_next", 32'(n_applied), 32'd1);

    // Reset while pending, mid-frame
    offer = '{10, 2, 3, 4, 8, 1, 2, 3};
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    for (int k = 0; k < 200 && (pos / h_total()) < 5; k++) cycle();
    do_reset();
    n_applied = 0;
    en = 1'b1;
    run(2 * DEF_FRAME + 4);
    check("rst_no_apply", 32'(n_applied), 32'd0);
    check("fs_period_rst", 32'(fs_period), 32'(DEF_FRAME));

    // Random configs with random enable gaps
    rand_en = 1'b1;
    repeat (6) begin
      run($urandom_range(0, 60));
      for (int i = 0; i < 8; i++)
        offer[i] = (i < 4) ? $urandom_range(1, 8) : $urandom_range(1, 6);
      n_applied = 0;
      cfg_valid = 1'b1;
      cycle();
      cfg_valid = 1'b0;
      for (int k = 0; k < 4000 && n_applied == 0; k++) cycle();
      check("rand_apply", 32'(n_applied), 32'd1);
    end
    rand_en = 1'b0;
    en = 1'b1;
    run(20);

`ifdef VGA_TIM_CFG_CHECK_EN
    // Zero sync width is rejected but consumed
    n_err = 0;
    offer = '{10, 2, 0, 4, 8, 1, 2, 3};
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    run(3);
    check("err_pulses", 32'(n_err), 32'd1);
    check("err_ready", 32'(cfg_ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
